// File: rtl/ram_arb_pkg.sv
// Shared types, default widths and the id-width helper for the RAM arbiter.
// Build option: RAM_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
package ram_arb_pkg;

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} ram_arb_state_t;

    localparam int RAM_ARB_ADDR_WIDTH = 10;
    localparam int RAM_ARB_DATA_WIDTH = 8;
    localparam int RAM_ARB_NUM_REQ    = 2;

    // Requester id width; never narrower than one bit.
    function automatic int ram_arb_id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side request/response bundle of the RAM arbiter.
// Handshake: a request commits on the rising edge where req_valid[i] && req_ready[i];
// requesters may drop valid before ready, and rsp_valid is a one-cycle pulse with no back-pressure.
interface ram_arbiter_if #(
    parameter int ADDR_WIDTH = ram_arb_pkg::RAM_ARB_ADDR_WIDTH,
    parameter int DATA_WIDTH = ram_arb_pkg::RAM_ARB_DATA_WIDTH,
    parameter int NUM_REQ    = ram_arb_pkg::RAM_ARB_NUM_REQ,
    parameter int ID_W       = ram_arb_pkg::ram_arb_id_w(NUM_REQ)
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            req_we;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic                          rsp_valid;
    logic [ID_W-1:0]               rsp_id;
    logic                          rsp_we;
    logic [DATA_WIDTH-1:0]         rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_id, rsp_we, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_id, rsp_we, rsp_rdata
    );
endinterface

// File: rtl/ram_arb_rr_pick.sv
// Combinational winner selection: round-robin search from rr_ptr with wrap,
// or lowest-index-wins when RAM_ARB_FIXED_PRIO_EN is defined.
module ram_arb_rr_pick
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ = RAM_ARB_NUM_REQ,
    parameter int ID_W    = ram_arb_id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

`ifdef RAM_ARB_FIXED_PRIO_EN
    logic unused_rr_ptr;
    assign unused_rr_ptr = ^rr_ptr;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant     = '0;
                grant[i]  = 1'b1;
                grant_idx = ID_W'(i);
            end
        end
    end
`else
    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;

    // Walk from the farthest candidate to rr_ptr itself so the closest valid one wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        sum       = '0;
        idx       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
            idx = sum[ID_W-1:0];
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port synchronous RAM between NUM_REQ requesters: one-cycle ACCESS per grant,
// registered response pulse. Build option RAM_ARB_FIXED_PRIO_EN drops the round-robin pointer.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = RAM_ARB_ADDR_WIDTH,
    parameter int DATA_WIDTH = RAM_ARB_DATA_WIDTH,
    parameter int NUM_REQ    = RAM_ARB_NUM_REQ,
    parameter int ID_W       = ram_arb_id_w(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    ram_arbiter_if.slave          bus,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    inout  wire  [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    output logic                  busy,
    output ram_arb_state_t        dbg_state
);

    ram_arb_state_t        state, next_state;
    logic [ID_W-1:0]       rr_ptr;
    logic [NUM_REQ-1:0]    pick_req;
    logic [NUM_REQ-1:0]    grant;
    logic [ID_W-1:0]       grant_idx;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic                  lat_we;
    logic [ID_W-1:0]       lat_id;
    logic                  in_access;

    assign pick_req  = (state == IDLE) ? bus.req_valid : '0;
    assign in_access = (state == ACCESS);

    ram_arb_rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
        .req       (pick_req),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        next_state    = state;
        bus.req_ready = '0;
        accept        = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = grant;
                accept        = |grant;
                if (accept) next_state = ACCESS;
            end
            ACCESS: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_addr  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_we    = bus.req_we[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

`ifdef RAM_ARB_FIXED_PRIO_EN
    assign rr_ptr = '0;
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         rr_ptr <= '0;
        else if (accept) rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_we    <= 1'b0;
            lat_id    <= '0;
        end else if (accept) begin
            lat_addr  <= sel_addr;
            lat_wdata <= sel_wdata;
            lat_we    <= sel_we;
            lat_id    <= grant_idx;
        end
    end

    // Read data is captured on the edge that ends ACCESS; a write response leaves rsp_rdata untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_we    <= 1'b0;
            bus.rsp_rdata <= '0;
        end else begin
            bus.rsp_valid <= in_access;
            if (in_access) begin
                bus.rsp_id <= lat_id;
                bus.rsp_we <= lat_we;
                if (!lat_we) bus.rsp_rdata <= ram_data;
            end
        end
    end

    assign ram_cs    = in_access;
    assign ram_addr  = in_access ? lat_addr : '0;
    assign ram_we    = in_access & lat_we;
    assign ram_oe    = in_access & ~lat_we;
    assign ram_data  = (in_access && lat_we) ? lat_wdata : 'z;
    assign busy      = in_access;
    assign dbg_state = state;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter with three requesters, a behavioural RAM and a transaction-level
// reference model compared every cycle, plus directed literal scenarios.
module tb_ram_arbiter;
    import ram_arb_pkg::*;

    localparam int AW = 10;
    localparam int DW = 8;
    localparam int NR = 3;
    localparam int IW = 2;
    localparam int RW = IW + 1 + DW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

    logic [AW-1:0]  ram_addr;
    wire  [DW-1:0]  ram_data;
    logic           ram_cs, ram_we, ram_oe, busy;
    ram_arb_state_t dbg_state;

    ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data),
        .ram_cs    (ram_cs),
        .ram_we    (ram_we),
        .ram_oe    (ram_oe),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    function automatic logic [DW-1:0] init_word(input int a);
        return DW'(a * 37 + 11);
    endfunction

    // ---------------- behavioural single-port RAM ----------------
    logic [DW-1:0] ram_mem [1<<AW];
    bit            ram_init = 1'b0;
    assign ram_data = (ram_cs && ram_oe) ? ram_mem[ram_addr] : 'z;
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int a = 0; a < (1<<AW); a++) ram_mem[a] <= init_word(a);
            ram_init <= 1'b1;
        end else if (ram_cs && ram_we) begin
            ram_mem[ram_addr] <= ram_data;
        end
    end

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    logic [DW-1:0] mem_m [1<<AW];
    bit            m_init = 1'b0;
    logic [RW-1:0] exp_q[$];
    bit            m_access;
    int            m_ptr;
    int            m_id;
    bit            m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    int            obs_grant_q[$];
    int            obs_gcyc_q[$];
    int            obs_rsp_q[$];

    // First valid requester searching upward from the start point, or -1.
    function automatic int pick_winner(input logic [NR-1:0] v, input int ptr);
        int start;
`ifdef RAM_ARB_FIXED_PRIO_EN
        start = 0 * ptr;
`else
        start = ptr;
`endif
        for (int k = 0; k < NR; k++) begin
            if (v[(start + k) % NR]) return (start + k) % NR;
        end
        return -1;
    endfunction

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin
        logic [NR-1:0] exp_ready;
        logic [RW-1:0] e;
        int            w;
        if (!m_init) begin
            for (int a = 0; a < (1<<AW); a++) mem_m[a] = init_word(a);
            m_init = 1'b1;
        end
        if (rst) begin
            m_access = 1'b0;
            m_ptr    = 0;
            m_rdata  = '0;
            exp_q.delete();
            check("rst_rsp_valid", bus.rsp_valid, 0);
            check("rst_rsp_id",    bus.rsp_id, 0);
            check("rst_rsp_rdata", bus.rsp_rdata, 0);
            check("rst_ram_cs",    ram_cs, 0);
            check("rst_req_ready", bus.req_ready, 0);
        end else begin
            for (int k = 0; k < NR; k++) begin
                if (bus.req_valid[k] && bus.req_ready[k]) begin
                    obs_grant_q.push_back(k);
                    obs_gcyc_q.push_back(cyc);
                end
            end
            if (bus.rsp_valid) obs_rsp_q.push_back(int'(bus.rsp_id));

            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rsp_valid",  bus.rsp_valid, 1);
                check("rsp_fields", {bus.rsp_id, bus.rsp_we, bus.rsp_rdata}, e);
            end else begin
                check("rsp_quiet", bus.rsp_valid, 0);
            end
            check("rsp_rdata_hold", bus.rsp_rdata, m_rdata);
            check("busy",   busy,   m_access);
            check("ram_cs", ram_cs, m_access);
            check("ram_we", ram_we, m_access && m_we);
            check("ram_oe", ram_oe, m_access && !m_we);
            if (m_access) begin
                check("ram_addr", ram_addr, m_addr);
                if (m_we) check("ram_data_drive", ram_data, m_wdata);
            end

            w = m_access ? -1 : pick_winner(bus.req_valid, m_ptr);
            exp_ready = '0;
            if (w >= 0) exp_ready[w] = 1'b1;
            check("req_ready", bus.req_ready, exp_ready);

            if (m_access) begin
                if (m_we) mem_m[m_addr] = m_wdata;
                else      m_rdata = mem_m[m_addr];
                exp_q.push_back({IW'(m_id), m_we, m_rdata});
                m_access = 1'b0;
            end else if (w >= 0) begin
                m_access = 1'b1;
                m_id     = w;
                m_we     = bus.req_we[w];
                m_addr   = bus.req_addr[w*AW +: AW];
                m_wdata  = bus.req_wdata[w*DW +: DW];
                m_ptr    = (w + 1) % NR;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        bus.req_valid = '0;
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_req(input int id, input bit we, input int addr, input int wdata, output int hs_cyc);
        bus.req_we[id]              = we;
        bus.req_addr[id*AW +: AW]   = AW'(addr);
        bus.req_wdata[id*DW +: DW]  = DW'(wdata);
        bus.req_valid[id]           = 1'b1;
        hs_cyc = -1;
        for (int t = 0; t < 20 && hs_cyc < 0; t++) begin
            @(negedge clk);
            if (bus.req_ready[id]) hs_cyc = cyc;
        end
        check("handshake_seen", hs_cyc >= 0, 1);
        @(posedge clk); #1;
        bus.req_valid[id] = 1'b0;
    endtask

    task automatic wait_rsp(output int rc, output int rid, output bit rwe, output logic [DW-1:0] rd);
        rc = -1; rid = 0; rwe = 1'b0; rd = '0;
        for (int t = 0; t < 20 && rc < 0; t++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                rc  = cyc;
                rid = int'(bus.rsp_id);
                rwe = bus.rsp_we;
                rd  = bus.rsp_rdata;
            end
        end
        check("rsp_seen", rc >= 0, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int            hs, rc, rid;
        bit            rwe;
        logic [DW-1:0] rd;
        int            exp_cont[4];
        int            exp_wrap[3];
        int            base;
`ifdef RAM_ARB_FIXED_PRIO_EN
        exp_cont = '{0, 0, 0, 0};
        exp_wrap = '{0, 1, 1};
`else
        exp_cont = '{0, 1, 0, 1};
        exp_wrap = '{0, 1, 2};
`endif
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        check("reset_busy",  busy, 0);
        check("reset_state", dbg_state, IDLE);

        // Write then read back from requester 0.
        do_req(0, 1'b1, 'h012, 'hA5, hs);
        check("wr_access_cs",   ram_cs,   1);
        check("wr_access_oe",   ram_oe,   0);
        check("wr_access_bus",  ram_data, 8'hA5);
        wait_rsp(rc, rid, rwe, rd);
        check("wr_latency", rc - hs, 2);
        check("wr_rsp_id",  rid, 0);
        check("wr_rsp_we",  rwe, 1);
        do_req(0, 1'b0, 'h012, 0, hs);
        check("rd_access_oe", ram_oe, 1);
        check("rd_access_we", ram_we, 0);
        wait_rsp(rc, rid, rwe, rd);
        check("rd_latency", rc - hs, 2);
        check("rd_rsp_we",  rwe, 0);
        check("rd_data",    rd, 8'hA5);

        // Contention between requesters 0 and 1.
        apply_reset();
        obs_grant_q.delete(); obs_gcyc_q.delete(); obs_rsp_q.delete();
        bus.req_we[0] = 1'b0; bus.req_addr[0*AW +: AW] = AW'('h001);
        bus.req_we[1] = 1'b0; bus.req_addr[1*AW +: AW] = AW'('h002);
        bus.req_valid[1:0] = 2'b11;
        repeat (16) @(posedge clk);
        #1 bus.req_valid = '0;
        repeat (4) @(posedge clk);
        #1;
        check("cont_grant_count", obs_grant_q.size(), 8);
        check("cont_rsp_count",   obs_rsp_q.size(), 8);
        for (int k = 0; k < 4; k++) begin
            if (obs_grant_q.size() > k) check("cont_grant", obs_grant_q[k], exp_cont[k]);
            if (obs_rsp_q.size() > k)   check("cont_rsp_id", obs_rsp_q[k], exp_cont[k]);
            if (k > 0 && obs_gcyc_q.size() > k) check("cont_spacing", obs_gcyc_q[k] - obs_gcyc_q[k-1], 2);
        end

        // Round-robin wrap: pointer at 2, only requester 0 valid, then 1 and 2 together.
        apply_reset();
        do_req(1, 1'b0, 'h010, 0, hs);
        wait_rsp(rc, rid, rwe, rd);
        check("wrap_pre_id", rid, 1);
        obs_grant_q.delete(); obs_gcyc_q.delete();
        do_req(0, 1'b0, 'h011, 0, hs);
        bus.req_we[1] = 1'b0; bus.req_addr[1*AW +: AW] = AW'('h012);
        bus.req_we[2] = 1'b0; bus.req_addr[2*AW +: AW] = AW'('h013);
        bus.req_valid[2:1] = 2'b11;
        repeat (4) @(posedge clk);
        #1 bus.req_valid = '0;
        repeat (4) @(posedge clk);
        #1;
        check("wrap_grant_count", obs_grant_q.size(), 3);
        for (int k = 0; k < 3; k++) begin
            if (obs_grant_q.size() > k) check("wrap_grant", obs_grant_q[k], exp_wrap[k]);
        end

        // Reset in the middle of a write access.
        do_req(0, 1'b1, 'h005, 'h77, hs);
        wait_rsp(rc, rid, rwe, rd);
        do_req(0, 1'b1, 'h005, 'h3C, hs);
        check("abort_cs_before", ram_cs, 1);
        #1 rst = 1'b1;
        #1;
        check("abort_cs_async",   ram_cs, 0);
        check("abort_busy_async", busy, 0);
        check("abort_state",      dbg_state, IDLE);
        obs_rsp_q.delete();
        @(posedge clk); #2 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("abort_no_rsp", obs_rsp_q.size(), 0);
        do_req(0, 1'b0, 'h005, 0, hs);
        wait_rsp(rc, rid, rwe, rd);
        check("abort_prior_value", rd, 8'h77);

        // Randomized traffic on a small address window.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NR; i++) begin
                bus.req_valid[i]            = ($urandom_range(0, 99) < 55);
                bus.req_we[i]               = $urandom_range(0, 1) == 1;
                bus.req_addr[i*AW +: AW]    = AW'($urandom_range(0, 15));
                bus.req_wdata[i*DW +: DW]   = DW'($urandom_range(0, 255));
            end
            @(posedge clk); #1;
        end
        bus.req_valid = '0;
        repeat (6) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
